// File: rtl/freq_div_sequencer_if.sv
// Bus between the control side (register writes, start/stop, divider feedback)
// and the frequency-divider sequencer.
interface freq_div_sequencer_if #(
   parameter int ADDR_W = 3,
   parameter int LEN_W  = 16
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_div;
   logic [LEN_W-1:0]  wr_len;
   logic              start;
   logic              stop;
   logic              loop;
   logic              div_clk_in;
   logic [31:0]       counter_init_val;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] step_idx;

   modport master (
      output wr_en, wr_addr, wr_div, wr_len, start, stop, loop, div_clk_in,
      input  counter_init_val, busy, done, step_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_div, wr_len, start, stop, loop, div_clk_in,
      output counter_init_val, busy, done, step_idx
   );
endinterface

// File: rtl/freq_div_sequencer.sv
// Steps the shared frequency divider through a table of (divisor, length)
// entries. Length counts toggles of the divided clock fed back on div_clk_in.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | not sequencing, divider held at IDLE_DIV
// S_RUN  | driving the current entry's divisor, counting toggles
// S_DONE | one-cycle done pulse after normal completion
module freq_div_sequencer #(
   parameter int          STEPS    = 8,
   parameter int          ADDR_W   = 3,
   parameter int          LEN_W    = 16,
   parameter logic [31:0] IDLE_DIV = 32'hFFFF_FFFF
) (
   input logic                 clk,
   input logic                 rst,
   freq_div_sequencer_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       div_tab [STEPS];
   logic [LEN_W-1:0]  len_tab [STEPS];
   logic              prev_div;
   logic              tog;
   logic [31:0]       cur_div;
   logic [LEN_W-1:0]  remaining;
   logic [ADDR_W-1:0] step_idx_q;
   logic [ADDR_W-1:0] nxt_idx;
   logic              seq_end;
   logic              load_en;
   logic [ADDR_W-1:0] load_idx;
   logic              dec_en;
   logic              clr_idx;

   assign tog     = (bus.div_clk_in != prev_div);
   assign nxt_idx = step_idx_q + ADDR_W'(1);
   // last slot, or the following entry is an end-of-sequence marker
   assign seq_end = (step_idx_q == ADDR_W'(STEPS - 1)) || (len_tab[nxt_idx] == '0);

   // Step table; new contents only matter when an entry is next loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STEPS; i++) begin
            div_tab[i] <= '0;
            len_tab[i] <= '0;
         end
      end else if (bus.wr_en) begin
         div_tab[bus.wr_addr] <= bus.wr_div;
         len_tab[bus.wr_addr] <= bus.wr_len;
      end
   end

   // Previous divided-clock level for toggle detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_div <= 1'b0;
      else     prev_div <= bus.div_clk_in;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state plus load/decrement/clear strobes for the step datapath
   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      load_idx  = '0;
      dec_en    = 1'b0;
      clr_idx   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (len_tab[0] != '0) begin
                  state_nxt = S_RUN;
                  load_en   = 1'b1;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_nxt = S_IDLE;
               clr_idx   = 1'b1;
            end else if (tog) begin
               // remaining is never 0 here, so the else-branches mean remaining==1
               if (remaining > LEN_W'(1)) begin
                  dec_en = 1'b1;
               end else if (!seq_end) begin
                  load_en  = 1'b1;
                  load_idx = nxt_idx;
               end else if (bus.loop && (len_tab[0] != '0)) begin
                  load_en = 1'b1;
               end else begin
                  state_nxt = S_DONE;
                  clr_idx   = 1'b1;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Current step: index, divisor and toggles left
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_idx_q <= '0;
         cur_div    <= '0;
         remaining  <= '0;
      end else if (load_en) begin
         step_idx_q <= load_idx;
         cur_div    <= div_tab[load_idx];
         remaining  <= len_tab[load_idx];
      end else if (clr_idx) begin
         step_idx_q <= '0;
         remaining  <= '0;
      end else if (dec_en) begin
         remaining  <= remaining - LEN_W'(1);
      end
   end

   // Outputs decoded from state; divider parked at IDLE_DIV outside RUN
   always_comb begin
      bus.busy             = (state == S_RUN);
      bus.done             = (state == S_DONE);
      bus.counter_init_val = (state == S_RUN) ? cur_div : IDLE_DIV;
      bus.step_idx         = step_idx_q;
   end

endmodule

// File: tb/tb_freq_div_sequencer.sv
// Directed scenarios plus a random soak, checked every cycle against a
// behavioural model of the sequencer kept in this bench.
module tb_freq_div_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   freq_div_sequencer_if #(.ADDR_W(3), .LEN_W(16)) sif ();

   freq_div_sequencer #(
      .STEPS(8), .ADDR_W(3), .LEN_W(16), .IDLE_DIV(32'hFFFF_FFFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   // divided-clock source: manual level or a simple divider model
   logic        dclk_man = 1'b0;
   logic        dclk_div = 1'b0;
   logic        use_div  = 1'b0;
   logic [31:0] dcnt     = '0;
   assign sif.div_clk_in = use_div ? dclk_div : dclk_man;

   // divider: output flips every counter_init_val+1 clocks
   always @(posedge clk) begin
      if (!use_div) dcnt <= '0;
      else if (dcnt >= sif.counter_init_val) begin
         dclk_div <= ~dclk_div;
         dcnt     <= '0;
      end else dcnt <= dcnt + 32'd1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [31:0] m_div [8];
   logic [15:0] m_len [8];
   bit          m_active;
   bit          m_done;
   int          m_idx;
   int          m_left;
   logic [31:0] m_val;
   logic        m_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_div[i] = '0;
         m_len[i] = '0;
      end
      m_active = 0; m_done = 0; m_idx = 0; m_left = 0; m_val = '0; m_prev = 1'b0;
   endtask

   task automatic model_load(input int k);
      m_idx  = k;
      m_val  = m_div[k];
      m_left = int'(m_len[k]);
   endtask

   // advance the model by one clock edge using the inputs about to be sampled
   task automatic model_clock();
      logic cur;
      bit   t;
      int   n;
      cur    = use_div ? dclk_div : dclk_man;
      t      = (cur !== m_prev);
      m_prev = cur;
      if (m_done) m_done = 0;
      else if (!m_active) begin
         if (sif.start) begin
            if (m_len[0] != 0) begin
               m_active = 1;
               model_load(0);
            end else m_done = 1;
         end
      end else if (sif.stop) begin
         m_active = 0;
         m_idx    = 0;
      end else if (t) begin
         if (m_left > 1) m_left--;
         else begin
            n = (m_idx + 1) % 8;
            if (m_idx == 7 || m_len[n] == 0) begin
               if (sif.loop && m_len[0] != 0) model_load(0);
               else begin
                  m_active = 0;
                  m_done   = 1;
                  m_idx    = 0;
               end
            end else model_load(n);
         end
      end
      if (sif.wr_en) begin
         m_div[sif.wr_addr] = sif.wr_div;
         m_len[sif.wr_addr] = sif.wr_len;
      end
   endtask

   task automatic compare();
      check("counter_init_val", sif.counter_init_val, m_active ? m_val : 32'hFFFF_FFFF);
      check("busy", {31'd0, sif.busy}, {31'd0, m_active});
      check("done", {31'd0, sif.done}, {31'd0, m_done});
      check("step_idx", {29'd0, sif.step_idx}, m_idx);
   endtask

   task automatic step();
      model_clock();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic tog(input int gap);
      repeat (gap) step();
      dclk_man = ~dclk_man;
      step();
   endtask

   task automatic wr(input int a, input logic [31:0] d, input int l);
      sif.wr_en   = 1'b1;
      sif.wr_addr = 3'(a);
      sif.wr_div  = d;
      sif.wr_len  = 16'(l);
      step();
      sif.wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      sif.start = 1'b1;
      step();
      sif.start = 1'b0;
   endtask

   task automatic pulse_stop();
      sif.stop = 1'b1;
      step();
      sif.stop = 1'b0;
   endtask

   task automatic run_out(input int maxc, input int gmax);
      int c = 0;
      while ((m_active || m_done) && c < maxc) begin
         tog($urandom_range(0, gmax));
         c++;
      end
      check("run_out_bound", {31'd0, c < maxc}, 32'd1);
   endtask

   // asynchronous reset asserted mid-cycle; outputs must react before any edge
   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_counter", sif.counter_init_val, 32'hFFFF_FFFF);
      check("rst_busy", {31'd0, sif.busy}, 32'd0);
      check("rst_done", {31'd0, sif.done}, 32'd0);
      check("rst_step_idx", {29'd0, sif.step_idx}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      compare();
   endtask

   initial begin
      int cyc;
      int last_t;
      int done_at;
      logic prv;

      sif.wr_en = 1'b0; sif.wr_addr = '0; sif.wr_div = '0; sif.wr_len = '0;
      sif.start = 1'b0; sif.stop = 1'b0; sif.loop = 1'b0;
      model_reset();
      do_reset();

      // basic sequence: 4 for 2 toggles, 9 for 3 toggles, then done
      wr(0, 32'd4, 2);
      wr(1, 32'd9, 3);
      wr(2, 32'd0, 0);
      sif.loop = 1'b0;
      pulse_start();
      check("basic_first_div", sif.counter_init_val, 32'd4);
      run_out(20, 3);
      idle(2);

      // loop twice through both entries, then stop
      sif.loop = 1'b1;
      pulse_start();
      for (int i = 0; i < 10; i++) tog($urandom_range(0, 2));
      pulse_stop();
      idle(2);

      // stop and toggle in the same cycle
      sif.loop = 1'b0;
      pulse_start();
      tog(1);
      dclk_man = ~dclk_man;
      sif.stop = 1'b1;
      step();
      sif.stop = 1'b0;
      check("stop_tog_idle", {31'd0, sif.busy}, 32'd0);
      idle(2);

      // start while running is ignored
      pulse_start();
      tog(0);
      pulse_start();
      run_out(20, 2);
      idle(1);

      // rewrite an entry while it is the active step
      pulse_start();
      tog(0);
      tog(0);
      wr(1, 32'd77, 3);
      check("wr_active_unchanged", sif.counter_init_val, 32'd9);
      sif.loop = 1'b1;
      repeat (5) tog($urandom_range(0, 1));
      check("wr_next_visit", sif.counter_init_val, 32'd77);
      pulse_stop();
      sif.loop = 1'b0;
      idle(1);

      // full table, one toggle per entry
      for (int i = 0; i < 8; i++) wr(i, $urandom, 1);
      pulse_start();
      run_out(20, 2);
      idle(1);

      // empty sequence: done next cycle, never busy
      wr(0, 32'd5, 0);
      pulse_start();
      check("len0_done", {31'd0, sif.done}, 32'd1);
      idle(2);

      // reset while running
      wr(0, 32'd6, 5);
      pulse_start();
      tog(1);
      do_reset();
      idle(2);

      // closed loop with the divider model, entry (2,4)
      wr(0, 32'd2, 4);
      dclk_man = dclk_div;
      idle(2);
      prv       = dclk_div;
      use_div   = 1'b1;
      sif.start = 1'b1;
      step();
      sif.start = 1'b0;
      cyc = 1; last_t = -1; done_at = 0;
      while (cyc < 30 && done_at == 0) begin
         step();
         cyc++;
         if (dclk_div != prv) begin
            if (last_t >= 0) check("div_spacing", cyc - last_t, 32'd3);
            last_t = cyc;
            prv    = dclk_div;
         end
         if (sif.done) done_at = cyc;
      end
      check("div_done_latency", {31'd0, (done_at > 0 && done_at <= 14)}, 32'd1);
      dclk_man = dclk_div;
      use_div  = 1'b0;
      idle(2);

      // random soak
      for (int i = 0; i < 1500; i++) begin
         if (i % 100 == 0) sif.loop = 1'($urandom_range(0, 1));
         sif.wr_en   = ($urandom_range(0, 9) == 0);
         sif.wr_addr = 3'($urandom_range(0, 7));
         sif.wr_div  = $urandom;
         sif.wr_len  = 16'($urandom_range(0, 4));
         sif.start   = ($urandom_range(0, 19) == 0);
         sif.stop    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 2) == 0) dclk_man = ~dclk_man;
         step();
      end
      sif.wr_en = 1'b0; sif.start = 1'b0; sif.stop = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
